// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the div20c8u16c complex-by-scalar divider.
package div_pkg;

    localparam int DW   = 20;
    localparam int ZW   = 8;
    localparam int QW   = 16;
    localparam int ITER = 15;
    localparam int CW   = 4;
    localparam logic signed [QW-1:0] QMAX = 16'sd32767;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sdiv_lane.sv
// One signed divide lane: (d*16)/div in sign-magnitude, one quotient bit per step, saturated to +/-32767.
// DIV_ROUND_EN: round magnitude to nearest (ties away from zero) instead of truncating.
module sdiv_lane
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic                  fin,
    input  logic [CW-1:0]         cnt,
    input  logic signed [DW-1:0]  d,
    input  logic [ZW-1:0]         div,
    output logic signed [QW-1:0]  q
);

    logic [DW-1:0]   mag;
    logic [DW+3:0]   num;
    logic            neg;
    logic            sat;
    logic [ZW-1:0]   r;
    logic [ITER-1:0] nlo;
    logic [ITER-1:0] qr;
    logic [CW-1:0]   bidx;
    logic [ZW:0]     rsh;
    logic            ge;
    logic [QW-1:0]   mag_q;

    assign mag  = d[DW-1] ? $unsigned(-d) : $unsigned(d);
    assign num  = {mag, 4'b0000};
    assign bidx = CW'(ITER-1) - cnt;
    assign rsh  = {r, nlo[bidx]};
    assign ge   = rsh >= {1'b0, div};

    always_comb begin
        mag_q = {1'b0, qr};
`ifdef DIV_ROUND_EN
        if ({r, 1'b0} >= {1'b0, div}) mag_q = mag_q + 1'b1;
`endif
        // |d| >= div<<11 (including div==0) never runs a meaningful division.
        if (sat || (mag_q > QMAX)) mag_q = QMAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg <= 1'b0;
            sat <= 1'b0;
            r   <= '0;
            nlo <= '0;
            qr  <= '0;
            q   <= '0;
        end else begin
            if (load) begin
                neg <= d[DW-1];
                sat <= num[DW+3:ITER] >= {1'b0, div};
                r   <= num[ITER+ZW-1:ITER];
                nlo <= num[ITER-1:0];
                qr  <= '0;
            end else if (step) begin
                r  <= ge ? ZW'(rsh - {1'b0, div}) : ZW'(rsh);
                qr <= {qr[ITER-2:0], ge};
            end
            if (fin) q <= neg ? -mag_q : mag_q;
        end
    end

endmodule

// File: rtl/div20c8u16c.sv
// Complex I/Q divide by unsigned 8-bit scalar: ov 17 clocks after accept, busy for 16, iv ignored while busy.
// DIV_ROUND_EN selects round-to-nearest in both lanes; latency and ports are unchanged.
module div20c8u16c
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [DW-1:0]  dix,
    input  logic signed [DW-1:0]  diy,
    input  logic [ZW-1:0]         diz,
    input  logic                  iv,
    output logic signed [QW-1:0]  dox,
    output logic signed [QW-1:0]  doy,
    output logic                  ov,
    output logic                  busy,
    output logic                  dz
);

    state_t        state, state_nxt;
    logic          load, step, fin;
    logic [CW-1:0] cnt;
    logic [ZW-1:0] diz_r;
    logic [ZW-1:0] div_cur;

    assign busy    = (state != IDLE);
    // Lanes see the live divisor on the accepting edge, the captured one afterwards.
    assign div_cur = (state == IDLE) ? diz : diz_r;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: if (iv) begin
                load      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(ITER-1)) state_nxt = DONE;
            end
            DONE: begin
                fin       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            diz_r <= '0;
            ov    <= 1'b0;
            dz    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt   <= '0;
                diz_r <= diz;
            end else if (step) begin
                cnt <= (cnt == CW'(ITER-1)) ? '0 : cnt + 1'b1;
            end
            ov <= fin;
            if (fin) dz <= (diz_r == '0);
        end
    end

    sdiv_lane u_lane_i (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .fin   (fin),
        .cnt   (cnt),
        .d     (dix),
        .div   (div_cur),
        .q     (dox)
    );

    sdiv_lane u_lane_q (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .fin   (fin),
        .cnt   (cnt),
        .d     (diy),
        .div   (div_cur),
        .q     (doy)
    );

endmodule

// File: tb/tb_div20c8u16c.sv
// Bench for div20c8u16c: directed table, flow-control and reset sequences, then random ops vs an arithmetic model.
module tb_div20c8u16c;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [19:0] dix, diy;
    logic [7:0]         diz;
    logic               iv;
    logic signed [15:0] dox, doy;
    logic               ov, busy, dz;

    int vectors = 0;
    int miscompares = 0;

    div20c8u16c dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dix   (dix),
        .diy   (diy),
        .diz   (diz),
        .iv    (iv),
        .dox   (dox),
        .doy   (doy),
        .ov    (ov),
        .busy  (busy),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int z;
        int ex;
        int ey;
        int edz;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: quotient of 16*d by z from plain integer arithmetic.
    function automatic int model_q(input int d, input int z);
        int m, q, rem;
        m = (d < 0) ? -d : d;
        if (z == 0 || m >= z * 2048) begin
            q = 32767;
        end else begin
            q   = (m * 16) / z;
            rem = (m * 16) % z;
`ifdef DIV_ROUND_EN
            if (2 * rem >= z) q = q + 1;
`endif
            if (q > 32767) q = 32767;
        end
        return (d < 0) ? -q : q;
    endfunction

    // Drive one request mid-cycle, let the next edge take it; returns at cycle 1.
    task automatic start(input int x, input int y, input int z);
        dix = 20'(x);
        diy = 20'(y);
        diz = 8'(z);
        iv  = 1'b1;
        @(posedge clk);
        #1;
        iv  = 1'b0;
    endtask

    // Counts cycles until ov, optionally pulsing iv with junk at cycles inj_a/inj_b.
    task automatic wait_ov(input int inj_a, input int inj_b, output int lat, output int nb);
        lat = 1;
        nb  = 0;
        while (!ov && lat < 40) begin
            if (lat == inj_a || lat == inj_b) begin
                iv  = 1'b1;
                dix = 20'(12345);
                diy = 20'(-777);
                diz = 8'd1;
            end else begin
                iv = 1'b0;
            end
            if (busy) nb++;
            @(posedge clk);
            #1;
            lat++;
        end
        iv = 1'b0;
        if (!ov) begin
            miscompares++;
            $display("FAIL timeout: no ov within %0d cycles", lat);
        end
    endtask

    task automatic run_check(input string tag, input int x, input int y, input int z,
                             input int ex, input int ey, input int edz,
                             input int inj_a, input int inj_b);
        int lat, nb;
        start(x, y, z);
        wait_ov(inj_a, inj_b, lat, nb);
        chk({tag, " dox"}, int'(dox), ex);
        chk({tag, " doy"}, int'(doy), ey);
        chk({tag, " dz"}, int'(dz), edz);
        chk({tag, " latency"}, lat, 17);
        chk({tag, " busy cycles"}, nb, 16);
        chk({tag, " busy at ov"}, int'(busy), 0);
    endtask

    initial begin
        int x, y, z, seen;

        tbl[0]  = '{100, -100, 4, 400, -400, 0};
`ifdef DIV_ROUND_EN
        tbl[1]  = '{11, -1600, 3, 59, -8533, 0};
        tbl[11] = '{1, -1, 32, 1, -1, 0};
`else
        tbl[1]  = '{11, -1600, 3, 58, -8533, 0};
        tbl[11] = '{1, -1, 32, 0, 0, 0};
`endif
        tbl[2]  = '{4096, -524288, 2, 32767, -32767, 0};
        tbl[3]  = '{2047, 0, 1, 32752, 0, 0};
        tbl[4]  = '{5, -5, 0, 32767, -32767, 1};
        tbl[5]  = '{0, 0, 7, 0, 0, 0};
        tbl[6]  = '{0, -1, 0, 32767, -32767, 1};
        tbl[7]  = '{524287, -524287, 255, 32767, -32767, 0};
        tbl[8]  = '{4095, -4094, 2, 32760, -32752, 0};
        tbl[9]  = '{1, -1, 255, 0, 0, 0};
        tbl[10] = '{7, -7, 2, 56, -56, 0};

        rst_n = 1'b0;
        iv    = 1'b0;
        dix   = '0;
        diy   = '0;
        diz   = '0;
        #3;
        chk("reset dox", int'(dox), 0);
        chk("reset doy", int'(doy), 0);
        chk("reset ov", int'(ov), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset dz", int'(dz), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++)
            run_check($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].z,
                      tbl[i].ex, tbl[i].ey, tbl[i].edz, -1, -1);

        // iv pulses during RUN must not disturb the running op.
        run_check("inject", 100, -100, 4, 400, -400, 0, 5, 10);
        // Back-to-back: request issued in the ov cycle.
        run_check("b2b", 11, -1600, 3, model_q(11, 3), model_q(-1600, 3), 0, -1, -1);
        @(posedge clk);
        #1;
        chk("ov pulse width", int'(ov), 0);
        chk("dox held", int'(dox), model_q(11, 3));
        chk("dz held", int'(dz), 0);

        // Reset at RUN iteration 8.
        start(5, -5, 0);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst dox", int'(dox), 0);
        chk("midrst doy", int'(doy), 0);
        chk("midrst ov", int'(ov), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst dz", int'(dz), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (ov || busy) seen++;
        end
        chk("no ov after reset", seen, 0);
        run_check("post reset", -300, 300, 9, model_q(-300, 9), model_q(300, 9), 0, -1, -1);

        for (int n = 0; n < 200; n++) begin
            logic signed [19:0] rx, ry;
            rx = 20'($urandom);
            ry = 20'($urandom);
            if (n % 7 == 0) rx = rx >>> 10;
            if (n % 11 == 0) ry = 20'sh80000;
            z = (n % 13 == 0) ? 0 : int'($urandom_range(255, 1));
            x = int'(rx);
            y = int'(ry);
            run_check($sformatf("rnd%0d", n), x, y, z, model_q(x, z), model_q(y, z),
                      (z == 0) ? 1 : 0, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div20c8u16c.md
DIV20C8U16C -- requirements
Module: div20c8u16c

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all logic.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have ports dix and diy, input, 20 bits each: signed two's-complement dividends (complex I/Q).
REQ-004 SHALL have port diz, input, 8 bits: unsigned common divisor.
REQ-005 SHALL have port iv, input, 1 bit: input valid; dix/diy/diz are sampled only when iv=1 and busy=0.
REQ-006 SHALL have ports dox and doy, output, 16 bits each: signed quotients, registered and held until the next result.
REQ-007 SHALL have port ov, output, 1 bit: one-cycle pulse that marks new dox/doy/dz.
REQ-008 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-009 SHALL have port dz, output, 1 bit: divide-by-zero flag, valid with ov and held afterwards.

Function
REQ-010 SHALL compute each quotient as (d*16)/diz with truncation toward zero, sign taken from d (inverse scaling of the companion complex-by-scalar multiplier).
REQ-011 SHALL work in sign-magnitude: |d| is 20 bits, |-524288| = 524288, and the numerator is N = |d|<<4 (24 bits).
REQ-012 SHALL saturate the magnitude to 32767 when |d| >= diz<<11, and SHALL apply the sign after saturation (range -32767..+32767; -32768 is never produced).
REQ-013 SHALL use restoring division with R0 = N>>15 and one quotient bit per clock over 15 iterations: R = {R, N[i]}, and if R >= diz then R = R - diz and the quotient bit is 1.
REQ-014 SHALL run the two channels in lockstep from one shared 4-bit iteration counter.
REQ-015 SHALL use states IDLE -> RUN (15 cycles) -> DONE (1 cycle, sign applied and outputs registered) -> IDLE.
REQ-016 SHALL produce ov exactly 17 clocks after the accepting iv edge, with busy=1 for the 16 clocks in between.
REQ-017 SHALL ignore iv while busy=1, with no effect on the operation in progress.
REQ-018 SHALL accept iv asserted in the cycle ov is high (busy=0 then), giving back-to-back throughput of one result per 17 clocks.
REQ-019 SHALL, when diz=0, set dz=1 and output +32767 for d>=0 or -32767 for d<0, with the same latency.
REQ-020 SHALL, when d=0 and diz!=0, output 0 with dz=0.

Reset
REQ-021 SHALL, on rst_n=0 at any time including mid-RUN, immediately abort and force state=IDLE, dox=0, doy=0, ov=0, busy=0, dz=0, counter=0.
REQ-022 SHALL require a new iv after rst_n deasserts; no partial result is ever emitted.

Configuration
REQ-023 SHALL, when macro DIV_ROUND_EN is defined, round to nearest (ties away from zero): in DONE, add 1 to the magnitude if 2*Rfinal >= diz, then saturate to 32767.
REQ-024 SHALL leave latency, ports and state machine unchanged by DIV_ROUND_EN.
REQ-025 SHALL truncate per REQ-010 when DIV_ROUND_EN is undefined.

Structure
REQ-026 SHALL place constants in package div_pkg: DW=20, ZW=8, QW=16, ITER=15, QMAX=16'sd32767, plus a state enum type (IDLE/RUN/DONE).
REQ-027 SHALL implement one sub-module, sdiv_lane (sign/magnitude conversion, remainder and quotient registers, saturation, optional rounding), instantiated twice (I and Q).
REQ-028 SHALL keep the FSM and counter in the top level.

Verification
REQ-029 SHALL cover: dix=100, diy=-100, diz=4 -> dox=400, doy=-400, dz=0, ov 17 clocks after iv.
REQ-030 SHALL cover: dix=11, diy=-1600, diz=3 -> dox=58 (59 with DIV_ROUND_EN), doy=-8533.
REQ-031 SHALL cover saturation: dix=4096, diy=-524288, diz=2 -> dox=32767, doy=-32767; and dix=2047, diz=1 -> dox=32752 (no saturation).
REQ-032 SHALL cover divide by zero: dix=5, diy=-5, diz=0 -> dox=32767, doy=-32767, dz=1.
REQ-033 SHALL cover flow control: iv pulsed at clocks 5 and 10 of a RUN -> second request ignored; iv in the ov cycle -> accepted, next ov 17 clocks later.
REQ-034 SHALL cover reset mid-operation: rst_n low at RUN iteration 8 -> all outputs 0 immediately, no ov afterwards until a new iv.
